// File: rtl/run_pkg.sv
// run_pkg: run-control state encodings shared by run_ctrl, the display mux and data_route.
package run_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        RUN_S   = 2'b00,
        PAUSE_S = 2'b01,
        DONE_S  = 2'b10
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_rise.sv
// sync_rise: two-flop synchronizer for an asynchronous panel button plus rising-edge detect.
module sync_rise (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic c1_q, c2_q, c3_q;
    logic c1_d, c2_d, c3_d;

    always_comb begin
        c1_d = din;
        c2_d = c1_q;
        c3_d = c2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c1_q <= 1'b0;
            c2_q <= 1'b0;
            c3_q <= 1'b0;
        end else begin
            c1_q <= c1_d;
            c2_q <= c2_d;
            c3_q <= c3_d;
        end
    end

    assign rise = c2_q & ~c3_q;

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: pipeline clock-enable generator with halt/resume/exit control and retire counters.
// The resume button port is continue_in because continue is a reserved word.
module run_ctrl
    import run_pkg::*;
#(
    parameter int FAST_DIV = 1,
    parameter int SLOW_DIV = 4,
    parameter int CNT_W    = 32,
    parameter int HALT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frequency,
    input  logic               continue_in,
    input  logic               halt_req,
    input  logic               exit_req,
    output logic               cpu_en,
    output logic [STATE_W-1:0] state,
    output logic               halted,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic [HALT_W-1:0]  halt_cnt
);

    localparam int DIV_W = $clog2(max_int(FAST_DIV, SLOW_DIV) + 1);
    localparam logic [DIV_W-1:0] FAST_V = DIV_W'(FAST_DIV);
    localparam logic [DIV_W-1:0] SLOW_V = DIV_W'(SLOW_DIV);

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [DIV_W-1:0]   cur_div_q, cur_div_d;
    logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic [HALT_W-1:0]  halt_cnt_q, halt_cnt_d;
    logic               rise;
    logic               resume;
    logic               take_halt;
    logic [DIV_W-1:0]   sel_div;

    sync_rise u_cont (
        .clk  (clk),
        .rst  (rst),
        .din  (continue_in),
        .rise (rise)
    );

    assign sel_div   = frequency ? FAST_V : SLOW_V;
    assign resume    = (state_q == PAUSE_S) && rise;
    assign take_halt = cpu_en && halt_req && !exit_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= RUN_S;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN_S:   state_d = (cpu_en && exit_req) ? DONE_S : take_halt ? PAUSE_S : RUN_S;
            PAUSE_S: state_d = rise ? RUN_S : PAUSE_S;
            DONE_S:  state_d = DONE_S;
            default: state_d = RUN_S;
        endcase
    end

    // rst gates cpu_en so a divide-by-one build never pulses while held in reset
    always_comb begin
        cpu_en = !rst && (state_q == RUN_S) && (div_cnt_q == cur_div_q - DIV_W'(1));
        halted = (state_q != RUN_S);
    end

    always_comb begin
        div_cnt_d   = div_cnt_q;
        cur_div_d   = cur_div_q;
        cycle_cnt_d = cycle_cnt_q;
        halt_cnt_d  = halt_cnt_q;
        if (cpu_en || resume) begin
            div_cnt_d = '0;
            cur_div_d = sel_div;
        end else if (state_q == RUN_S) begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end
        if (cpu_en && (cycle_cnt_q != '1))
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        if (take_halt)
            halt_cnt_d = halt_cnt_q + HALT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q   <= '0;
            cur_div_q   <= SLOW_V;
            cycle_cnt_q <= '0;
            halt_cnt_q  <= '0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            cur_div_q   <= cur_div_d;
            cycle_cnt_q <= cycle_cnt_d;
            halt_cnt_q  <= halt_cnt_d;
        end
    end

    assign state     = state_q;
    assign cycle_cnt = cycle_cnt_q;
    assign halt_cnt  = halt_cnt_q;

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed checks of run_ctrl rate division, halt/resume, exit and reset.
module tb_run_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        frequency;
    logic        continue_in;
    logic        halt_req;
    logic        exit_req;
    logic        cpu_en;
    logic [1:0]  state;
    logic        halted;
    logic [31:0] cycle_cnt;
    logic [15:0] halt_cnt;
    int          checks = 0;
    int          errors = 0;
    int          n;

    run_ctrl #(.FAST_DIV(1), .SLOW_DIV(4), .CNT_W(32), .HALT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .frequency   (frequency),
        .continue_in (continue_in),
        .halt_req    (halt_req),
        .exit_req    (exit_req),
        .cpu_en      (cpu_en),
        .state       (state),
        .halted      (halted),
        .cycle_cnt   (cycle_cnt),
        .halt_cnt    (halt_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; frequency = 1'b0; continue_in = 1'b0; halt_req = 1'b0; exit_req = 1'b0;
        step(); step();
        check("rst_state", 32'(state), 32'd0);
        check("rst_en", 32'(cpu_en), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_cycle", cycle_cnt, 32'd0);
        check("rst_halt", 32'(halt_cnt), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check("slow_en", 32'(cpu_en), 32'((i % 4) == 3));
            step();
        end
        check("slow_cycle", cycle_cnt, 32'd3);
        frequency = 1'b1;
        for (int j = 0; j < 8; j++) begin
            check("toggle_en", 32'(cpu_en), 32'(j >= 3));
            step();
        end
        check("toggle_cycle", cycle_cnt, 32'd8);
        for (int k = 0; k < 10; k++) begin
            check("fast_en", 32'(cpu_en), 32'd1);
            step();
        end
        check("fast_cycle", cycle_cnt, 32'd18);
        check("fast_state", 32'(state), 32'd0);
        check("fast_halted", 32'(halted), 32'd0);
        halt_req = 1'b1;
        check("halt_pulse_en", 32'(cpu_en), 32'd1);
        step();
        halt_req = 1'b0;
        check("pause_state", 32'(state), 32'd1);
        check("pause_halted", 32'(halted), 32'd1);
        check("pause_halt_cnt", 32'(halt_cnt), 32'd1);
        check("pause_cycle", cycle_cnt, 32'd19);
        n = 0;
        repeat (100) begin
            n += 32'(cpu_en);
            step();
        end
        check("pause_idle_en", 32'(n), 32'd0);
        check("pause_idle_cycle", cycle_cnt, 32'd19);
        continue_in = 1'b1;
        step();
        continue_in = 1'b0;
        check("resume_k", 32'(state), 32'd1);
        step();
        check("resume_k1", 32'(state), 32'd1);
        step();
        check("resume_k2", 32'(state), 32'd0);
        check("resume_en", 32'(cpu_en), 32'd1);
        check("resume_halt_cnt", 32'(halt_cnt), 32'd1);
        frequency = 1'b0;
        step();
        check("resume_cycle", cycle_cnt, 32'd20);
        halt_req = 1'b1;
        repeat (3) begin
            check("ign_halt_en", 32'(cpu_en), 32'd0);
            step();
            check("ign_halt_state", 32'(state), 32'd0);
        end
        halt_req = 1'b0;
        check("stale_en_a", 32'(cpu_en), 32'd1);
        continue_in = 1'b1;
        step();
        continue_in = 1'b0;
        step(); step();
        check("stale_run", 32'(state), 32'd0);
        check("stale_noen", 32'(cpu_en), 32'd0);
        step();
        check("stale_en_b", 32'(cpu_en), 32'd1);
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        check("halt2_state", 32'(state), 32'd1);
        check("halt2_cnt", 32'(halt_cnt), 32'd2);
        check("halt2_cycle", cycle_cnt, 32'd22);
        repeat (10) step();
        check("stale_hold", 32'(state), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_cycle", cycle_cnt, 32'd0);
        check("midrst_halt", 32'(halt_cnt), 32'd0);
        check("midrst_halted", 32'(halted), 32'd0);
        step();
        check("midrst_en", 32'(cpu_en), 32'd0);
        rst = 1'b0;
        frequency = 1'b1;
        step(); step(); step();
        check("exit_en", 32'(cpu_en), 32'd1);
        halt_req = 1'b1;
        exit_req = 1'b1;
        step();
        halt_req = 1'b0;
        exit_req = 1'b0;
        check("done_state", 32'(state), 32'd2);
        check("done_halted", 32'(halted), 32'd1);
        check("done_halt_cnt", 32'(halt_cnt), 32'd0);
        check("done_cycle", cycle_cnt, 32'd1);
        continue_in = 1'b1;
        repeat (3) step();
        continue_in = 1'b0;
        n = 0;
        repeat (10) begin
            n += 32'(cpu_en);
            step();
        end
        check("done_idle_en", 32'(n), 32'd0);
        check("done_hold", 32'(state), 32'd2);
        rst = 1'b1;
        #1;
        check("done_rst_state", 32'(state), 32'd0);
        step();
        rst = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
